// File: rtl/interrupt_arbiter.sv
// Four-source interrupt arbiter: edge-captured sticky pending flags, fixed or
// rotating priority, one-hot registered grants held until ack or timeout.
module interrupt_arbiter #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned TW      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       m,
  input  logic       inta,
  input  logic       intb,
  input  logic       intc,
  input  logic       intd,
  input  logic       ack,
  output logic       sa,
  output logic       sb,
  output logic       sc,
  output logic       sd,
  output logic       irq,
  output logic [3:0] pending,
  output logic       tmo
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_RELEASE
  } state_t;

  localparam logic [TW-1:0] LP_CNT_LAST = TW'(TIMEOUT - 1);

  state_t        r_state;
  logic [3:0]    r_hist;
  logic [3:0]    r_pend;
  logic [3:0]    r_sel;
  logic [1:0]    r_ptr;
  logic [1:0]    r_win;
  logic [TW-1:0] r_cnt;
  logic          r_tmo;
  logic          r_irq;

  state_t        w_state_nxt;
  logic [3:0]    w_int;
  logic [3:0]    w_rise;
  logic [3:0]    w_clr;
  logic [3:0]    w_pend_nxt;
  logic [3:0]    w_sel_nxt;
  logic [1:0]    w_ptr_nxt;
  logic [1:0]    w_win_nxt;
  logic [1:0]    w_pick;
  logic [TW-1:0] w_cnt_nxt;
  logic          w_tmo_nxt;
  logic          w_irq_nxt;

  // Fixed mode searches from A; rotating mode searches from the pointer, wrapping D->A.
  function automatic logic [1:0] f_pick(input logic [3:0] req, input logic rot,
                                        input logic [1:0] start);
    logic [1:0] base;
    logic [1:0] idx;
    logic [1:0] res;
    logic       found;
    base  = rot ? start : 2'd0;
    res   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      idx = base + k[1:0];
      if (!found && req[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  always_comb begin
    w_int       = {intd, intc, intb, inta};
    w_rise      = w_int & ~r_hist;
    w_pick      = f_pick(r_pend, m, r_ptr);
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    w_win_nxt   = r_win;
    w_cnt_nxt   = r_cnt;
    w_tmo_nxt   = 1'b0;
    w_clr       = '0;

    unique case (r_state)
      ST_IDLE: begin
        if (|r_pend) begin
          w_win_nxt   = w_pick;
          w_sel_nxt   = 4'd1 << w_pick;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (ack) begin
          w_clr       = 4'd1 << r_win;
          w_sel_nxt   = '0;
          w_ptr_nxt   = r_win + 2'd1;
          w_state_nxt = ST_RELEASE;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_sel_nxt   = '0;
          w_tmo_nxt   = 1'b1;
          w_ptr_nxt   = r_win + 2'd1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_RELEASE: begin
        w_sel_nxt = '0;
        if (!ack) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_sel_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase

    // A new rising edge overrides a same-cycle clear.
    w_pend_nxt = (r_pend & ~w_clr) | w_rise;
    w_irq_nxt  = (|w_pend_nxt) | (|w_sel_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_hist  <= '0;
      r_pend  <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
      r_win   <= '0;
      r_cnt   <= '0;
      r_tmo   <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hist  <= w_int;
      r_pend  <= w_pend_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
      r_win   <= w_win_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tmo   <= w_tmo_nxt;
      r_irq   <= w_irq_nxt;
    end
  end

  assign sa      = r_sel[0];
  assign sb      = r_sel[1];
  assign sc      = r_sel[2];
  assign sd      = r_sel[3];
  assign pending = r_pend;
  assign tmo     = r_tmo;
  assign irq     = r_irq;

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Self-checking bench for interrupt_arbiter: cycle model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_interrupt_arbiter;

  localparam int unsigned TIMEOUT = 15;
  localparam int unsigned TW      = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       m    = 1'b0;
  logic       inta = 1'b0;
  logic       intb = 1'b0;
  logic       intc = 1'b0;
  logic       intd = 1'b0;
  logic       ack  = 1'b0;
  logic       sa, sb, sc, sd, irq, tmo;
  logic [3:0] pending;
  logic [3:0] sel;

  int errors = 0;
  int checks = 0;

  // Model state: granted source (-1 = none), release phase, cycles held, pointer.
  bit [3:0] md_pend  = '0;
  bit [3:0] md_prev  = '0;
  int       md_gsrc  = -1;
  bit       md_rel   = 1'b0;
  int       md_held  = 0;
  int       md_ptr   = 0;
  bit       md_tmo   = 1'b0;
  bit [3:0] md_ins;
  int       md_clr;
  int       md_idx;

  interrupt_arbiter #(.TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk(clk), .rst_n(rst_n), .m(m),
    .inta(inta), .intb(intb), .intc(intc), .intd(intd), .ack(ack),
    .sa(sa), .sb(sb), .sc(sc), .sd(sd),
    .irq(irq), .pending(pending), .tmo(tmo)
  );

  always #5 clk = ~clk;
  assign sel = {sd, sc, sb, sa};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_pend = '0; md_prev = '0; md_gsrc = -1; md_rel = 1'b0;
      md_held = 0;  md_ptr  = 0;  md_tmo  = 1'b0;
    end else begin
      md_ins = {intd, intc, intb, inta};
      md_clr = -1;
      md_tmo = 1'b0;
      if (md_gsrc >= 0) begin
        if (ack) begin
          md_clr  = md_gsrc;
          md_ptr  = (md_gsrc + 1) % 4;
          md_gsrc = -1;
          md_rel  = 1'b1;
        end else if (md_held == int'(TIMEOUT)) begin
          md_tmo  = 1'b1;
          md_ptr  = (md_gsrc + 1) % 4;
          md_gsrc = -1;
        end else begin
          md_held++;
        end
      end else if (md_rel) begin
        if (!ack) md_rel = 1'b0;
      end else begin
        for (int k = 0; k < 4; k++) begin
          md_idx = m ? (md_ptr + k) % 4 : k;
          if (md_gsrc < 0 && md_pend[md_idx]) begin
            md_gsrc = md_idx;
            md_held = 1;
          end
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (md_ins[i] && !md_prev[i]) md_pend[i] = 1'b1;
        else if (i == md_clr)         md_pend[i] = 1'b0;
      end
      md_prev = md_ins;
    end
  end

  always @(negedge clk) begin
    chk("model_sel", sel, (md_gsrc >= 0) ? (32'd1 << md_gsrc) : 32'd0);
    chk("model_pending", pending, md_pend);
    chk("model_irq", irq, (|md_pend) || (md_gsrc >= 0));
    chk("model_tmo", tmo, md_tmo);
  end

  task automatic pulse(input logic [3:0] mask);
    {intd, intc, intb, inta} = mask;
    @(negedge clk);
    {intd, intc, intb, inta} = '0;
  endtask

  task automatic serve();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic wait_grant(input int budget, output logic [3:0] got, output int cycles);
    got    = '0;
    cycles = 0;
    while (cycles < budget && got == 4'b0000) begin
      @(negedge clk);
      cycles++;
      got = sel;
    end
    if (got == 4'b0000) begin
      checks++;
      errors++;
      $display("FAIL grant_wait: no grant within %0d cycles", budget);
    end
  endtask

  initial begin
    logic [3:0] g;
    logic [3:0] exp_p [4];
    int         c;
    int         hi;
    int         grants;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_sel", sel, 4'b0000);
    chk("reset_pending", pending, 4'b0000);
    chk("reset_irq", irq, 1'b0);
    chk("reset_tmo", tmo, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Async reset mid-grant on B
    pulse(4'b0010);
    wait_grant(10, g, c);
    chk("t1_grant_b", g, 4'b0010);
    chk("t1_latency", c, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_async_sel", sel, 4'b0000);
    chk("t1_async_pending", pending, 4'b0000);
    chk("t1_async_irq", irq, 1'b0);
    chk("t1_async_tmo", tmo, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("t1_after_pending", pending, 4'b0000);

    // Fixed priority, all four rise together
    m = 1'b0;
    exp_p = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};
    pulse(4'b1111);
    chk("t2_pending_all", pending, 4'b1111);
    for (int i = 0; i < 4; i++) begin
      wait_grant(10, g, c);
      chk("t2_order", g, 4'd1 << i);
      chk("t2_gap", c, (i == 0) ? 1 : 2);
      serve();
      chk("t2_pending_step", pending, exp_p[i]);
    end
    repeat (2) @(negedge clk);
    chk("t2_irq_idle", irq, 1'b0);

    // Rotating priority; pointer is at A after D was serviced
    m = 1'b1;
    pulse(4'b0001);
    wait_grant(10, g, c);
    chk("t3_a_first", g, 4'b0001);
    serve();
    pulse(4'b0101);
    wait_grant(10, g, c);
    chk("t3_c_before_a", g, 4'b0100);
    serve();
    pulse(4'b0010);
    wait_grant(10, g, c);
    chk("t3_a_before_b", g, 4'b0001);
    serve();
    wait_grant(10, g, c);
    chk("t3_b_last", g, 4'b0010);
    serve();
    repeat (2) @(negedge clk);

    // Timeout on B with ack never asserted
    m = 1'b0;
    pulse(4'b0010);
    wait_grant(10, g, c);
    chk("t4_grant_b", g, 4'b0010);
    hi = 1;
    while (sb && hi < 100) begin
      @(negedge clk);
      if (sb) hi++;
    end
    chk("t4_hold_cycles", hi, TIMEOUT);
    chk("t4_tmo_pulse", tmo, 1'b1);
    chk("t4_pending_kept", pending[1], 1'b1);
    @(negedge clk);
    chk("t4_tmo_single", tmo, 1'b0);
    chk("t4_regrant_b", sel, 4'b0010);
    serve();
    repeat (2) @(negedge clk);

    // Set and clear of A coincide
    pulse(4'b0001);
    wait_grant(10, g, c);
    chk("t5_grant_a", g, 4'b0001);
    ack  = 1'b1;
    inta = 1'b1;
    @(negedge clk);
    ack  = 1'b0;
    inta = 1'b0;
    chk("t5_pending_set_wins", pending[0], 1'b1);
    chk("t5_released", sel, 4'b0000);
    wait_grant(10, g, c);
    chk("t5_regrant_a", g, 4'b0001);
    chk("t5_regrant_gap", c, 2);
    serve();
    chk("t5_pending_clear", pending, 4'b0000);
    repeat (2) @(negedge clk);

    // Level-held C is serviced once
    intc   = 1'b1;
    grants = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sc) begin
        grants++;
        ack = 1'b1;
      end else begin
        ack = 1'b0;
      end
    end
    intc = 1'b0;
    ack  = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_single_grant", grants, 1);
    chk("t6_pending_c_low", pending[2], 1'b0);
    pulse(4'b0100);
    chk("t6_pending_c_rearm", pending[2], 1'b1);
    wait_grant(10, g, c);
    chk("t6_grant_c", g, 4'b0100);
    serve();
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/interrupt_arbiter.md
Name: interrupt_arbiter

Overview:
Sequential four-source interrupt arbiter placed directly upstream of the mode-selectable interrupt combiner (m, inta..intd, sa..sd -> y).
- Captures rising edges on inta..intd into sticky pending flags.
- Selects one winner, by fixed or rotating priority according to m.
- Drives the one-hot service/select lines sa..sd consumed by the combiner.
- Holds a grant until the serviced source acknowledges, or until a timeout expires.

Parameters:
TIMEOUT, 15, cycles a grant may remain in GRANT without ack before it is withdrawn (1..255).
TW, 8, width of the timeout counter; must satisfy TIMEOUT < 2**TW.

Ports:
clk  input  1  single system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
m  input  1  priority mode: 0 = fixed (a>b>c>d), 1 = rotating
inta  input  1  interrupt source A, synchronous to clk
intb  input  1  interrupt source B, synchronous to clk
intc  input  1  interrupt source C, synchronous to clk
intd  input  1  interrupt source D, synchronous to clk
ack  input  1  acknowledge from the servicing agent (level)
sa  output  1  grant/select A (registered)
sb  output  1  grant/select B (registered)
sc  output  1  grant/select C (registered)
sd  output  1  grant/select D (registered)
irq  output  1  high while any pending flag is set or a grant is active
pending  output  4  sticky pending flags {d,c,b,a}
tmo  output  1  one-cycle pulse when a grant times out

Behaviour:
- Reset (rst_n=0, asynchronous):
  - sa..sd=0, irq=0, pending=0, tmo=0.
  - State=IDLE, rotate pointer=A, edge-detect history=0, counter=0.
  - Reset asserted mid-grant drops the grant immediately. The pending request is lost.
- Edge capture: pending[i] sets on the clk edge where int_i=1 and its previous sampled value=0. Level-high inputs do not re-set the flag.
- Pending clear: pending[i] clears only on acknowledged service of source i. If a set and a clear coincide in the same cycle, set wins and the bit stays 1.
- States:
  - IDLE:
    - If pending!=0, compute the winner and go to GRANT.
    - The winner's s-line is registered high on the same edge; exactly one of sa..sd is high.
    - The timeout counter loads 0.
  - GRANT:
    - The s-line is held stable and the counter increments each cycle.
    - ack=1: clear the winner's pending bit, drop the s-line, set pointer = winner+1 (mod 4), go to RELEASE.
    - Otherwise, when the counter reaches TIMEOUT-1: drop the s-line, keep the pending bit, pulse tmo for 1 cycle, set pointer = winner+1, go to IDLE.
    - ack has priority over timeout in the same cycle.
  - RELEASE: all s-lines are 0. Wait for ack=0, then go to IDLE. No new grant is issued while ack stays high.
- Winner selection:
  - m=0: lowest index set wins (A first).
  - m=1: search starts at the pointer and wraps D->A.
  - m is sampled only in IDLE; changing m during GRANT/RELEASE has no effect until the next arbitration.
- Latency:
  - int rising before edge E1 sets pending at E1.
  - The grant is visible after E2 (2 cycles).
  - Back-to-back service costs at least 1 RELEASE cycle plus 1 IDLE cycle between grants.
- irq = |pending | any s-line (registered), so it is glitch-free.
- The pointer updates only on ack or timeout. In fixed mode the pointer is still maintained but ignored.

Test Plan:
1. Reset: rst_n=0 asynchronously mid-GRANT on B -> sa..sd=0000, pending=0000, irq=0, tmo=0 within the same cycle, with no clock edge required.
2. Fixed priority: m=0, inta..intd rise together, ack raised 1 cycle after each grant and dropped 1 cycle later.
   -> grant order A,B,C,D, each grant 2 cycles after the previous ack falls.
   -> pending steps 1111 -> 1110 -> 1100 -> 1000 -> 0000.
3. Rotating priority: m=1, after A serviced, intA and intC both pend -> C granted before A. After C, a new B request -> D absent, so A is granted before B.
4. Timeout: TIMEOUT=15, intb rises, ack never asserted.
   -> sb high for exactly 15 cycles, then tmo pulses 1 cycle and pending[1] stays 1.
   -> sb is re-granted 1 cycle later, since it is the only pending source.
5. Simultaneous set/clear: inta re-rises in the same cycle that ack clears A -> pending[0] remains 1 and A is granted again after RELEASE.
6. Level hold: intc held high for 40 cycles, serviced once -> exactly one grant to C; pending[2]=0 afterwards until intc falls and rises again.
